// File: rtl/cache_mem_pkg.sv
// Shared types and widths for the cache's slow line-memory responder.
package cache_mem_pkg;

  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port and one registered read port.
module mem_line_array
  import cache_mem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] lineMem [0:(1<<IDX_W)-1];
  logic [LINE_W-1:0] rdata_q;

  // Storage itself is never reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lineMem[waddr_i] <= wdata_i;
    end
  end

  // Output register holds the last read line until the next read.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= lineMem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Slow line memory under the cache: latch a request, wait LATENCY cycles,
// commit/read the line and pulse mem_ready for one cycle.
module cache_mem_responder
  import cache_mem_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 8
) (
  input  logic                  clk,
  input  logic                  proc_reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]     mem_wdata,
  output logic [LINE_W-1:0]     mem_rdata,
  output logic                  mem_ready,
  output logic                  proto_err
);

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

  state_e            state_q;
  logic [7:0]        cnt_q;
  op_e               op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic              ready_q;
  logic              protoErr_q;

  logic              req;
  logic              goResp;
  op_e               commitOp;
  logic [IDX_W-1:0]  commitIdx;
  logic [LINE_W-1:0] commitData;
  logic              arrWe;
  logic              arrRe;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^mem_addr[MEM_ADDR_W-1:IDX_W];

  // With LATENCY==1 the commit happens on the same edge that samples the
  // request, so the array must be fed from the live inputs in IDLE.
  always_comb begin
    req        = mem_read | mem_write;
    goResp     = 1'b0;
    commitOp   = op_q;
    commitIdx  = idx_q;
    commitData = wdata_q;
    if (state_q == IDLE) begin
      commitOp   = mem_write ? OP_WR : OP_RD;
      commitIdx  = mem_addr[IDX_W-1:0];
      commitData = mem_wdata;
      goResp     = req && (LATENCY == 1);
    end else if (state_q == BUSY) begin
      goResp     = (cnt_q == 8'd0);
    end
    goResp = goResp && !proc_reset;
    arrWe  = goResp && (commitOp == OP_WR);
    arrRe  = goResp && (commitOp == OP_RD);
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_RD;
      idx_q      <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            op_q    <= mem_write ? OP_WR : OP_RD;
            idx_q   <= mem_addr[IDX_W-1:0];
            wdata_q <= mem_wdata;
            if (mem_read && mem_write) begin
              protoErr_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_line_array #(
    .IDX_W(IDX_W)
  ) u_array (
    .clk_i   (clk),
    .reset_i (proc_reset),
    .we_i    (arrWe),
    .waddr_i (commitIdx),
    .wdata_i (commitData),
    .re_i    (arrRe),
    .raddr_i (commitIdx),
    .rdata_o (mem_rdata)
  );

  assign mem_ready = ready_q;
  assign proto_err = protoErr_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized scoreboard bench for cache_mem_responder at LATENCY 4 and 1.
module tb_cache_mem_responder;
  import cache_mem_pkg::*;

  localparam int IDX_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  procReset;
  logic [1:0]            rdV, wrV, readyV, perrV;
  logic [1:0][27:0]      addrV;
  logic [1:0][127:0]     wdataV, rdataV;

  cache_mem_responder #(.LATENCY(4), .IDX_W(IDX_W)) dut4 (
    .clk(clk), .proc_reset(procReset),
    .mem_read(rdV[0]), .mem_write(wrV[0]), .mem_addr(addrV[0]), .mem_wdata(wdataV[0]),
    .mem_rdata(rdataV[0]), .mem_ready(readyV[0]), .proto_err(perrV[0])
  );

  cache_mem_responder #(.LATENCY(1), .IDX_W(IDX_W)) dut1 (
    .clk(clk), .proc_reset(procReset),
    .mem_read(rdV[1]), .mem_write(wrV[1]), .mem_addr(addrV[1]), .mem_wdata(wdataV[1]),
    .mem_rdata(rdataV[1]), .mem_ready(readyV[1]), .proto_err(perrV[1])
  );

  typedef struct {
    logic [127:0] rdata;
    int           readyAt;
    logic         perr;
  } exp_t;

  exp_t         expQ0[$];
  exp_t         expQ1[$];
  logic [127:0] refMem [int];
  logic [127:0] modelRdata [2];
  logic         modelPerr [2];
  int           freeCycle [2];
  logic         prevReady [2];
  int           cyc = 0;
  int           checkCount = 0;
  int           passCount = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int inst);
    return (inst == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every mem_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      if (readyV[i]) begin
        have = 1'b0;
        if (i == 0 && expQ0.size() > 0) begin e = expQ0.pop_front(); have = 1'b1; end
        if (i == 1 && expQ1.size() > 0) begin e = expQ1.pop_front(); have = 1'b1; end
        if (!have) begin
          checkCount++;
          $display("[TB] FAIL unexpectedReady%0d: got mem_ready=1 at cycle %0d, expected none", i, cyc);
        end else begin
          chk($sformatf("readyCycle%0d", i), 128'(cyc), 128'(e.readyAt));
          chk($sformatf("rdata%0d", i), rdataV[i], e.rdata);
          chk($sformatf("protoErr%0d", i), 128'(perrV[i]), 128'(e.perr));
          chk($sformatf("pulseWidth%0d", i), 128'(prevReady[i]), 128'(0));
        end
      end
      prevReady[i] = readyV[i];
    end
  end

  // Drive one request from a negedge; the model serialises transactions and
  // predicts the response cycle from when the responder is next idle.
  task automatic applyStimulus(input int inst, input logic r, input logic w,
                               input logic [27:0] a, input logic [127:0] d, input bit expectDone);
    exp_t e;
    int   first;
    int   key;
    bit   got;
    rdV[inst] = r; wrV[inst] = w; addrV[inst] = a; wdataV[inst] = d;
    if (!expectDone) return;
    first     = (cyc > freeCycle[inst]) ? cyc : freeCycle[inst];
    e.readyAt = first + lat(inst);
    freeCycle[inst] = e.readyAt + 1;
    key = inst * 4096 + int'(a[IDX_W-1:0]);
    if (r && w) modelPerr[inst] = 1'b1;
    if (w) begin
      refMem[key] = d;
      e.rdata = modelRdata[inst];
    end else begin
      e.rdata = refMem.exists(key) ? refMem[key] : 128'h0;
      modelRdata[inst] = e.rdata;
    end
    e.perr = modelPerr[inst];
    if (inst == 0) expQ0.push_back(e); else expQ1.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (readyV[inst]) begin got = 1'b1; break; end
    end
    if (!got) begin
      checkCount++;
      $display("[TB] FAIL readyTimeout%0d: got no mem_ready, expected one at cycle %0d", inst, e.readyAt);
    end
  endtask

  task automatic idle(input int inst, input int n);
    rdV[inst] = 1'b0; wrV[inst] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [127:0] randLine();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] r0, input logic [127:0] r1);
    chk({tag, "Rdata0"}, rdataV[0], r0);
    chk({tag, "Rdata1"}, rdataV[1], r1);
    chk({tag, "Ready0"}, 128'(readyV[0]), 128'(0));
    chk({tag, "Ready1"}, 128'(readyV[1]), 128'(0));
    chk({tag, "Perr0"}, 128'(perrV[0]), 128'(modelPerr[0]));
    chk({tag, "Perr1"}, 128'(perrV[1]), 128'(modelPerr[1]));
  endtask

  task automatic randomRun(input int inst, input int n);
    logic [31:0] upper;
    logic [7:0]  idx;
    logic        w;
    int          gap;
    for (int i = 0; i < n; i++) begin
      upper = $urandom();
      idx   = 8'($urandom_range(0, 31));
      w     = 1'($urandom_range(0, 1));
      applyStimulus(inst, !w, w, {upper[19:0], idx}, randLine(), 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(inst, gap);
    end
    idle(inst, 1);
  endtask

  initial begin
    procReset = 1'b1;
    rdV = '0; wrV = '0; addrV = '0; wdataV = '0;
    for (int i = 0; i < 2; i++) begin
      modelRdata[i] = '0; modelPerr[i] = 1'b0; freeCycle[i] = 0; prevReady[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset", 128'h0, 128'h0);
    procReset = 1'b0;
    freeCycle[0] = cyc; freeCycle[1] = cyc;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1'b0, 1'b1, 28'(i), randLine(), 1'b1);
    end
    idle(0, 1);

    applyStimulus(0, 1'b0, 1'b1, 28'h0000010, 128'h0000_0004_0000_0003_0000_0002_0000_0001, 1'b1);
    idle(0, 1);
    applyStimulus(0, 1'b1, 1'b0, 28'h0000010, 128'h0, 1'b1);
    idle(0, 2);

    // Write-back then allocate switched in the ready cycle, aliased index.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000005, randLine(), 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 28'hABC0005, 128'h0, 1'b1);
    idle(0, 2);

    applyStimulus(0, 1'b0, 1'b1, 28'h0000001, {4{32'h11111111}}, 1'b1);
    idle(0, 1);
    applyStimulus(0, 1'b1, 1'b0, 28'h0000001, 128'h0, 1'b1);
    idle(0, 1);
    applyStimulus(0, 1'b0, 1'b1, 28'h0000002, randLine(), 1'b1);
    idle(0, 1);

    // Reset while a write to idx 7 is in BUSY: no commit, no response.
    applyStimulus(0, 1'b0, 1'b1, 28'h0000007, {4{32'hAAAAAAAA}}, 1'b1);
    idle(0, 1);
    applyStimulus(0, 1'b0, 1'b1, 28'h0000007, {4{32'h5A5A5A5A}}, 1'b0);
    repeat (2) @(negedge clk);
    procReset = 1'b1;
    rdV[0] = 1'b0; wrV[0] = 1'b0;
    @(negedge clk);
    procReset = 1'b0;
    modelRdata[0] = '0; modelRdata[1] = '0;
    modelPerr[0] = 1'b0; modelPerr[1] = 1'b0;
    checkOutput("midReset", 128'h0, 128'h0);
    freeCycle[0] = cyc; freeCycle[1] = cyc;
    idle(0, 4);
    applyStimulus(0, 1'b1, 1'b0, 28'h0000007, 128'h0, 1'b1);
    idle(0, 1);

    applyStimulus(0, 1'b1, 1'b1, 28'h0000003, {4{32'h55555555}}, 1'b1);
    idle(0, 1);
    chk("protoErrSet", 128'(perrV[0]), 128'(1));
    applyStimulus(0, 1'b1, 1'b0, 28'h0000003, 128'h0, 1'b1);
    idle(0, 1);

    randomRun(0, 40);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 1'b0, 1'b1, 28'(i), randLine(), 1'b1);
      if (i % 3 == 0) idle(1, 1);
    end
    idle(1, 2);
    applyStimulus(1, 1'b1, 1'b0, 28'h0000005, 128'h0, 1'b1);
    idle(1, 3);
    randomRun(1, 40);

    for (int k = 0; k < 100 && (expQ0.size() + expQ1.size()) > 0; k++) @(negedge clk);
    chk("queuesDrained", 128'(expQ0.size() + expQ1.size()), 128'(0));
    chk("protoErrSticky0", 128'(perrV[0]), 128'(1));
    chk("protoErrClear1", 128'(perrV[1]), 128'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the direct-mapped cache's 128-bit line interface (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready).
- Latches one line request and waits a programmable latency. It then commits the write or returns the read line, and pulses mem_ready for one cycle.
- Synthesizable slow-memory model used under the cache in CPU-level simulation and FPGA bring-up.

Parameters:
- LATENCY, 4, cycles from request first seen in IDLE to the mem_ready cycle; legal range 1..255.
- IDX_W, 8, line-index width; storage depth = 2**IDX_W lines of 128 bits.

Ports:
- clk  input  1  clock, rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request, held by the cache until mem_ready.
- mem_write  input  1  line write request, held by the cache until mem_ready.
- mem_addr  input  28  line address; only mem_addr[IDX_W-1:0] indexes storage, upper bits alias.
- mem_wdata  input  128  write line; word 0 is in bits [31:0].
- mem_rdata  output  128  read line; registered, valid in the mem_ready cycle.
- mem_ready  output  1  one-cycle completion pulse, registered.
- proto_err  output  1  sticky flag: mem_read and mem_write were both seen high in IDLE.

Behaviour:
- Reset: state=IDLE, mem_ready=0, mem_rdata=0, proto_err=0, counter=0. Storage contents are not reset; they are undefined until written.
- States:
  - IDLE: if mem_read|mem_write in cycle t, latch op, addr index and wdata at the end of t. Go to RESP if LATENCY==1, else go to BUSY with cnt=LATENCY-2.
  - BUSY: decrement cnt. At cnt==0, go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then unconditionally go to IDLE.
- Timing: mem_ready is high in cycle t+LATENCY exactly.
- Write commit: the latched line is written at the edge entering RESP.
- Read data: the line is read at the edge entering RESP into mem_rdata. mem_rdata holds its value until the next read response; write responses leave mem_rdata unchanged.
- Input sampling: request inputs are ignored in BUSY and RESP, because latched copies are used. A request present in the RESP cycle (the cache's write-back-to-allocate switch) is not captured there. It is captured in the following IDLE cycle if still asserted.
- Throughput: at least one IDLE cycle between transactions. A back-to-back write-back then allocate completes in 2*LATENCY+1 cycles from the write being first seen.
- mem_read and mem_write both high in IDLE: treat as a write (write wins) and set proto_err. proto_err is cleared only by reset.
- Reset mid-operation (BUSY): abort. No storage write occurs, and no mem_ready is issued.
- Read-after-write to the same index returns the new data; this holds because commit precedes the next IDLE sample.
- Index aliasing: addresses differing only above IDX_W map to the same line.

Decomposition:
- Package cache_mem_pkg:
  - LINE_W=128, MEM_ADDR_W=28.
  - State encoding IDLE=2'b00, BUSY=2'b01, RESP=2'b10.
  - Op enum {OP_RD, OP_WR}.
- Sub-module mem_line_array: 2**IDX_W x 128 storage, one synchronous write port and one synchronous read port on the same clk.
- FSM, counter and latches live in the top module.

Test Plan:
- LATENCY=4: write addr 0x0000010 data 0x0000_0004_0000_0003_0000_0002_0000_0001, held until ready -> mem_ready high exactly 4 cycles after first-seen, pulse width 1. A following read of 0x0000010 -> mem_rdata equals the written line in its ready cycle.
- Write-back/allocate sequence: write idx 5, and in its ready cycle switch to a read of idx 5 with new upper tag bits -> the read is captured in the next IDLE. Second mem_ready arrives 9 cycles after the write was first seen, with the line just written (aliasing).
- LATENCY=1: read request in cycle t -> mem_ready in t+1. Request deasserted in t+1 -> no second pulse.
- Reset asserted during BUSY of a write to idx 7 (old value 0xAA..AA) -> no mem_ready. A subsequent read of idx 7 returns 0xAA..AA; mem_rdata=0 right after reset.
- mem_read=mem_write=1 in IDLE, wdata=0x55..55, idx 3 -> proto_err rises and stays high. A later read of idx 3 returns 0x55..55.
- Write response leaves mem_rdata unchanged: read idx 1 (0x11..11), then write idx 2 -> mem_rdata still 0x11..11 in the write's ready cycle.
